// File: rtl/audio_note_sequencer.sv
// Multi-channel note-duration sequencer.
// Queues {dur, pitch} note commands per channel and plays each note for
// exactly dur frame ticks. Queued notes on a channel play back-to-back.
// Ports:
//   clk25, reset (async, active-low)  - system clock and reset
//   frclk                             - frame clock level input, synchronised internally
//   cmd_valid/cmd_ready               - command handshake (cmd_ready is combinational)
//   cmd_chan/cmd_stop/cmd_dur/cmd_pitch - command payload
//   audioEn                           - per-channel play enable (registered)
//   pitch_out                         - per-channel pitch, channel c at [c*PITCH_W +: PITCH_W]
//   fifo_full                         - per-channel FIFO full flag (registered)
module audio_note_sequencer #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DUR_W    = 17,
  parameter int unsigned PITCH_W  = 8,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk25,
  input  logic                        reset,
  input  logic                        frclk,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [CW-1:0]               cmd_chan,
  input  logic                        cmd_stop,
  input  logic [DUR_W-1:0]            cmd_dur,
  input  logic [PITCH_W-1:0]          cmd_pitch,
  output logic [CHANNELS-1:0]         audioEn,
  output logic [CHANNELS*PITCH_W-1:0] pitch_out,
  output logic [CHANNELS-1:0]         fifo_full
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned DW   = DUR_W + PITCH_W;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  // Frame clock synchroniser and rising-edge detector
  logic [1:0] fr_sync;
  logic       fr_d;
  logic       tick;

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      fr_sync <= 2'b00;
      fr_d    <= 1'b0;
    end else begin
      fr_sync <= {fr_sync[0], frclk};
      fr_d    <= fr_sync[1];
    end
  end

  assign tick = fr_sync[1] & ~fr_d;

  // Command decode; out-of-range channels are always accepted and dropped
  logic chan_ok;
  logic sel_full;
  logic accept;

  assign chan_ok = (32'(cmd_chan) < CHANNELS);

  always_comb begin
    sel_full = 1'b0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (chan_ok && (cmd_chan == CW'(c))) sel_full = fifo_full[c];
    end
  end

  assign cmd_ready = cmd_stop | ~sel_full | ~chan_ok;
  assign accept    = cmd_valid & cmd_ready;

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    logic [DW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CNTW-1:0]    count, count_nxt;
    logic [DUR_W-1:0]   remaining;
    logic [DUR_W-1:0]   head_dur;
    logic [PITCH_W-1:0] head_pitch;
    logic [PITCH_W-1:0] pitch_q;
    logic               en_q, full_q;
    logic               hit, stop_hit, push, pop, empty, last_tick;
    state_t             state;

    assign hit       = chan_ok && (cmd_chan == CW'(c));
    assign stop_hit  = accept & cmd_stop & hit;
    assign push      = accept & ~cmd_stop & hit;
    assign empty     = (count == '0);
    assign {head_dur, head_pitch} = mem[rd_ptr];
    // Final tick of the current note; the next entry is popped on the same edge
    assign last_tick = (state == PLAY) && tick && (remaining == DUR_W'(1));
    assign pop       = ~stop_hit & ~empty & ((state == IDLE) | last_tick);

    always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + CNTW'(1);
      else if (pop && !push) count_nxt = count - CNTW'(1);
    end

    // Note storage (no reset needed; occupancy guards reads)
    always_ff @(posedge clk25) begin
      if (push) mem[wr_ptr] <= {cmd_dur, cmd_pitch};
    end

    // FIFO pointers and play state machine; stop flushes and wins over all else
    always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
        state     <= IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        full_q    <= 1'b0;
        en_q      <= 1'b0;
        pitch_q   <= '0;
        remaining <= '0;
      end else if (stop_hit) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        full_q <= 1'b0;
        en_q   <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count  <= count_nxt;
        full_q <= (count_nxt == CNTW'(DEPTH));
        case (state)
          IDLE: begin
            // Zero-duration entries are popped and dropped
            if (pop && (head_dur != '0)) begin
              remaining <= head_dur;
              pitch_q   <= head_pitch;
              state     <= PLAY;
              en_q      <= 1'b1;
            end
          end
          PLAY: begin
            if (tick) begin
              if (remaining == DUR_W'(1)) begin
                if (pop && (head_dur != '0)) begin
                  remaining <= head_dur;
                  pitch_q   <= head_pitch;
                end else begin
                  state <= IDLE;
                  en_q  <= 1'b0;
                end
              end else begin
                remaining <= remaining - DUR_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            en_q  <= 1'b0;
          end
        endcase
      end
    end

    assign audioEn[c]                         = en_q;
    assign fifo_full[c]                       = full_q;
    assign pitch_out[c*PITCH_W +: PITCH_W]    = pitch_q;
  end

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed self-checking bench for audio_note_sequencer.
module tb_audio_note_sequencer;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DUR_W    = 17;
  localparam int unsigned PITCH_W  = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = 2;

  logic                        clk25 = 1'b0;
  logic                        reset;
  logic                        frclk;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [CW-1:0]               cmd_chan;
  logic                        cmd_stop;
  logic [DUR_W-1:0]            cmd_dur;
  logic [PITCH_W-1:0]          cmd_pitch;
  logic [CHANNELS-1:0]         audioEn;
  logic [CHANNELS*PITCH_W-1:0] pitch_out;
  logic [CHANNELS-1:0]         fifo_full;

  int checks   = 0;
  int failures = 0;

  always #20 clk25 = ~clk25;

  audio_note_sequencer #(
    .CHANNELS(CHANNELS),
    .DUR_W   (DUR_W),
    .PITCH_W (PITCH_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk25    (clk25),
    .reset    (reset),
    .frclk    (frclk),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_chan (cmd_chan),
    .cmd_stop (cmd_stop),
    .cmd_dur  (cmd_dur),
    .cmd_pitch(cmd_pitch),
    .audioEn  (audioEn),
    .pitch_out(pitch_out),
    .fifo_full(fifo_full)
  );

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One command presented for exactly one edge
  task automatic push_cmd(input int ch, input int stp, input int d, input int p);
    cmd_chan  = CW'(ch);
    cmd_stop  = 1'(stp);
    cmd_dur   = DUR_W'(d);
    cmd_pitch = PITCH_W'(p);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  // After tick_pre the next edge samples the tick
  task automatic tick_pre();
    frclk = 1'b1;
    step();
    step();
  endtask

  task automatic tick_post();
    frclk = 1'b0;
    step();
    step();
  endtask

  task automatic do_tick();
    tick_pre();
    step();
    tick_post();
  endtask

  initial begin
    reset = 1'b0; frclk = 1'b0; cmd_valid = 1'b0; cmd_stop = 1'b0;
    cmd_chan = '0; cmd_dur = '0; cmd_pitch = '0;
    #5;
    check("rst_en",    32'(audioEn),   0);
    check("rst_pitch", pitch_out,      0);
    check("rst_full",  32'(fifo_full), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    step(); step();
    reset = 1'b1;
    step();

    // ch0 single note, dur 3
    push_cmd(0, 0, 3, 'h40);
    check("t1_en_accept", 32'(audioEn[0]), 0);
    step();
    check("t1_en_load",  32'(audioEn),         'b0001);
    check("t1_pitch",    32'(pitch_out[7:0]),  'h40);
    do_tick();
    do_tick();
    check("t1_en_2ticks", 32'(audioEn[0]), 1);
    tick_pre();
    check("t1_en_pre3", 32'(audioEn[0]), 1);
    step();
    check("t1_en_off",     32'(audioEn[0]),     0);
    check("t1_pitch_hold", 32'(pitch_out[7:0]), 'h40);
    tick_post();

    // ch1 gapless pair {2,0x10},{1,0x20}
    push_cmd(1, 0, 2, 'h10);
    push_cmd(1, 0, 1, 'h20);
    check("t2_en_load", 32'(audioEn),          'b0010);
    check("t2_pitch_a", 32'(pitch_out[15:8]),  'h10);
    do_tick();
    tick_pre();
    check("t2_pitch_a_pre", 32'(pitch_out[15:8]), 'h10);
    step();
    check("t2_en_gapless", 32'(audioEn[1]),      1);
    check("t2_pitch_b",    32'(pitch_out[15:8]), 'h20);
    tick_post();
    tick_pre();
    step();
    check("t2_en_off", 32'(audioEn[1]), 0);
    tick_post();

    // ch2 fill: one note playing plus four queued
    push_cmd(2, 0, 2, 'h21);
    push_cmd(2, 0, 2, 'h22);
    push_cmd(2, 0, 2, 'h23);
    push_cmd(2, 0, 2, 'h24);
    check("t3_not_full", 32'(fifo_full), 0);
    push_cmd(2, 0, 2, 'h25);
    check("t3_full", 32'(fifo_full), 'b0100);
    cmd_chan = 2'd2; cmd_stop = 1'b0; #1;
    check("t3_ready_full", 32'(cmd_ready), 0);
    cmd_chan = 2'd3; #1;
    check("t3_ready_ch3", 32'(cmd_ready), 1);
    cmd_chan = 2'd2; cmd_stop = 1'b1; #1;
    check("t3_ready_stop", 32'(cmd_ready), 1);
    cmd_stop = 1'b0;
    do_tick();
    check("t3_full_hold", 32'(fifo_full), 'b0100);
    // Offer a note on the popping edge; it must be refused
    tick_pre();
    cmd_chan = 2'd2; cmd_dur = 17'd1; cmd_pitch = 8'h77; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("t3_full_after_pop", 32'(fifo_full),         0);
    check("t3_pitch_next",     32'(pitch_out[23:16]),  'h22);
    check("t3_en_next",        32'(audioEn[2]),        1);
    tick_post();
    push_cmd(2, 1, 0, 0);
    check("t3_stop_en",   32'(audioEn[2]),  0);
    check("t3_stop_full", 32'(fifo_full),   0);
    step();
    check("t3_stop_stays", 32'(audioEn[2]), 0);

    // Stop ch0 on a tick edge with two notes queued; ch1 keeps playing
    push_cmd(1, 0, 5, 'h31);
    push_cmd(0, 0, 3, 'h41);
    push_cmd(0, 0, 3, 'h42);
    push_cmd(0, 0, 3, 'h43);
    check("t4_en_both",  32'(audioEn),         'b0011);
    check("t4_pitch_c0", 32'(pitch_out[7:0]),  'h41);
    tick_pre();
    cmd_chan = 2'd0; cmd_stop = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_stop = 1'b0;
    check("t4_en0_off",   32'(audioEn[0]),      0);
    check("t4_pitch0",    32'(pitch_out[7:0]),  'h41);
    check("t4_en1_on",    32'(audioEn[1]),      1);
    check("t4_pitch1",    32'(pitch_out[15:8]), 'h31);
    tick_post();
    check("t4_en0_flushed", 32'(audioEn[0]), 0);

    // ch3: zero-duration note skipped, then a 1-tick note
    push_cmd(3, 0, 0, 'h99);
    push_cmd(3, 0, 1, 'h55);
    check("t5_en_skip",    32'(audioEn[3]),        0);
    check("t5_pitch_skip", 32'(pitch_out[31:24]),  0);
    step();
    check("t5_en_on",  32'(audioEn[3]),       1);
    check("t5_pitch",  32'(pitch_out[31:24]), 'h55);
    tick_pre();
    check("t5_en_pre", 32'(audioEn[3]), 1);
    step();
    check("t5_en_off",     32'(audioEn[3]),       0);
    check("t5_pitch_hold", 32'(pitch_out[31:24]), 'h55);
    tick_post();
    // ch1 note of 5 ticks has seen 2 ticks so far
    do_tick();
    do_tick();
    tick_pre();
    check("t4_en1_pre5", 32'(audioEn[1]), 1);
    step();
    check("t4_en1_off5", 32'(audioEn[1]), 0);
    tick_post();

    // Asynchronous reset during play on all channels
    push_cmd(0, 0, 10, 'h61);
    push_cmd(1, 0, 10, 'h62);
    push_cmd(2, 0, 10, 'h63);
    push_cmd(3, 0, 10, 'h64);
    push_cmd(0, 0, 10, 'h65);
    check("t6_en_all",    32'(audioEn), 'hF);
    check("t6_pitch_all", pitch_out,    'h64636261);
    #5;
    reset = 1'b0;
    #1;
    check("t6_rst_en",    32'(audioEn),   0);
    check("t6_rst_pitch", pitch_out,      0);
    check("t6_rst_full",  32'(fifo_full), 0);
    step(); step();
    reset = 1'b1;
    step(); step();
    check("t6_queue_lost", 32'(audioEn), 0);
    push_cmd(1, 0, 1, 'h7A);
    check("t6_en_accept", 32'(audioEn), 0);
    step();
    check("t6_en_load", 32'(audioEn), 'b0010);
    check("t6_pitch",   pitch_out,    'h00007A00);
    tick_pre();
    step();
    check("t6_en_off", 32'(audioEn), 0);
    tick_post();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
